board_debounce: RTL

Input conditioning stage for the evaluation-board push buttons and toggle switches. It synchronizes the raw asynchronous `key`/`sw` pad signals into the Wishbone clock domain and debounces them per bit. It then drives the `key` and `sw` inputs of the board I/O Wishbone slave. It also produces single-cycle edge pulses for later use as interrupt or event sources.

---
 rtl/board_debounce.sv | 103 ++++++++++
 1 files changed

// File: rtl/board_debounce.sv
// board_debounce: synchronizes and debounces the evaluation-board push buttons
// and toggle switches, and emits registered single-cycle edge pulses.
// Key channels are active-low and rest high. Switch channels rest low.
module board_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_in,
    input  logic [9:0] sw_in,
    output logic [3:0] key,
    output logic [9:0] sw,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [9:0] sw_change
);

    // Channels 0..3 are keys, channels 4..13 are switches.
    localparam int unsigned NCH = 14;
    localparam logic [NCH-1:0] RST_VAL = {10'b0, 4'hF};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        COMMIT
    } phase_t;

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   stable;
    logic [NCH-1:0]   commit;
    logic [CNT_W-1:0] cnt      [NCH];
    logic [CNT_W-1:0] cnt_next [NCH];
    phase_t           phase    [NCH];

    logic [3:0]       press_q;
    logic [3:0]       release_q;
    logic [9:0]       change_q;

    assign raw = {sw_in, key_in};

    // Classify each channel as IDLE, COUNT or COMMIT and compute its next count.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            phase[i]    = IDLE;
            cnt_next[i] = '0;
            commit[i]   = 1'b0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    phase[i]  = COMMIT;
                    commit[i] = 1'b1;
                end else begin
                    phase[i]    = COUNT;
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchronizer, debounced level and per-channel counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= RST_VAL;
            s2     <= RST_VAL;
            stable <= RST_VAL;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_next[i];
                if (phase[i] == COMMIT) begin
                    stable[i] <= s2[i];
                end
            end
        end
    end

    // Edge pulses are registered so they line up with the debounced output change.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_q   <= '0;
            release_q <= '0;
            change_q  <= '0;
        end else begin
            press_q   <= commit[3:0] & ~s2[3:0];
            release_q <= commit[3:0] &  s2[3:0];
            change_q  <= commit[13:4];
        end
    end

    assign key         = stable[3:0];
    assign sw          = stable[13:4];
    assign key_press   = press_q;
    assign key_release = release_q;
    assign sw_change   = change_q;

endmodule
